// File: rtl/als_light_filter_pkg.sv
// Shared constants for the ambient-light filter: frame field positions, zero-field mask,
// default hysteresis thresholds and the malformed-frame test.
package als_pkg;

    localparam int          ALS_CODE_W        = 8;
    localparam int          ALS_DATA_MSB      = 11;
    localparam int          ALS_DATA_LSB      = 4;
    localparam logic [15:0] ALS_ZERO_MASK     = 16'hF00F;
    localparam logic [7:0]  ALS_THRESH_HI_DEF = 8'd160;
    localparam logic [7:0]  ALS_THRESH_LO_DEF = 8'd96;

    // A well-formed frame carries zeros outside the light-code field
    function automatic logic alsFrameBad(input logic [15:0] frame);
        return |(frame & ALS_ZERO_MASK);
    endfunction

endpackage

// File: rtl/als_light_filter_moving_avg.sv
// Moving-average window over the last 2^LOG2_DEPTH accepted light codes.
// The average and its valid flag are presented in the same cycle as the accepted sample.
module als_moving_avg
    import als_pkg::*;
#(
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [ALS_CODE_W-1:0] in_data,
    output logic [ALS_CODE_W-1:0] avg,
    output logic                  avg_valid
);

    localparam int                  DEPTH     = 1 << LOG2_DEPTH;
    localparam int                  SUM_W     = ALS_CODE_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0] FILL_LAST = {1'b0, {LOG2_DEPTH{1'b1}}};

    logic [ALS_CODE_W-1:0] r_buffer [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wptr;
    logic [SUM_W-1:0]      r_sum;
    logic [LOG2_DEPTH:0]   r_fill;
    logic [ALS_CODE_W-1:0] w_oldest;
    logic [SUM_W-1:0]      w_nextSum;

    // The sum always contains the oldest entry, so subtracting it can never underflow
    assign w_oldest  = r_buffer[r_wptr];
    assign w_nextSum = r_sum + SUM_W'(in_data) - SUM_W'(w_oldest);
    assign avg       = ALS_CODE_W'(w_nextSum >> LOG2_DEPTH);
    assign avg_valid = in_valid && (r_fill >= FILL_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buffer[i] <= '0;
            end
            r_wptr <= '0;
            r_sum  <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_buffer[r_wptr] <= in_data;
            r_sum            <= w_nextSum;
            r_wptr           <= r_wptr + LOG2_DEPTH'(1);
            if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + (LOG2_DEPTH + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/als_light_filter.sv
// Samples the SPI receiver's frame mid-period, averages the light code and drives a hysteresis flag.
// Define ALS_FRAME_CHECK_EN to discard malformed frames and count them in err_cnt.
module als_light_filter
    import als_pkg::*;
#(
    parameter int         CNT_W      = 22,
    parameter int         LOG2_DEPTH = 3,
    parameter logic [7:0] THRESH_HI  = ALS_THRESH_HI_DEF,
    parameter logic [7:0] THRESH_LO  = ALS_THRESH_LO_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value_in,
    output logic [7:0]  light,
    output logic        light_valid,
    output logic        bright,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    // Mid-period tick keeps sampling far from the upstream update at its counter wrap
    localparam logic [CNT_W-1:0] TICK_AT = {1'b1, {(CNT_W - 1){1'b0}}};

    logic [CNT_W-1:0]      r_timer;
    logic [15:0]           r_capture;
    logic                  r_sampleValid;
    logic [ALS_CODE_W-1:0] r_light;
    logic                  r_lightValid;
    logic                  r_bright;
    logic                  w_tick;
    logic                  w_frameBad;
    logic                  w_accept;
    logic [ALS_CODE_W-1:0] w_avg;
    logic                  w_avgValid;

    assign w_tick = (r_timer == TICK_AT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer       <= '0;
            r_capture     <= '0;
            r_sampleValid <= 1'b0;
        end else begin
            r_timer       <= r_timer + CNT_W'(1);
            r_sampleValid <= w_tick;
            if (w_tick) begin
                r_capture <= value_in;
            end
        end
    end

`ifdef ALS_FRAME_CHECK_EN
    logic [7:0] r_errCnt;

    assign w_frameBad = alsFrameBad(r_capture);
    assign frame_err  = r_sampleValid & w_frameBad;
    assign err_cnt    = r_errCnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_errCnt <= '0;
        end else if (frame_err && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end
`else
    logic w_unusedBits;

    assign w_frameBad   = 1'b0;
    assign w_unusedBits = ^{r_capture[15:12], r_capture[3:0]};
    assign frame_err    = 1'b0;
    assign err_cnt      = '0;
`endif

    assign w_accept = r_sampleValid & ~w_frameBad;

    als_moving_avg #(
        .LOG2_DEPTH(LOG2_DEPTH)
    ) u_movingAvg (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (w_accept),
        .in_data  (r_capture[ALS_DATA_MSB:ALS_DATA_LSB]),
        .avg      (w_avg),
        .avg_valid(w_avgValid)
    );

    // Between the two thresholds the flag keeps its previous value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_light      <= '0;
            r_lightValid <= 1'b0;
            r_bright     <= 1'b0;
        end else begin
            r_lightValid <= w_avgValid;
            if (w_avgValid) begin
                r_light <= w_avg;
                if (w_avg >= THRESH_HI) begin
                    r_bright <= 1'b1;
                end else if (w_avg <= THRESH_LO) begin
                    r_bright <= 1'b0;
                end
            end
        end
    end

    assign light       = r_light;
    assign light_valid = r_lightValid;
    assign bright      = r_bright;

endmodule

// File: tb/tb_als_light_filter.sv
// Self-checking bench for als_light_filter (CNT_W=6, LOG2_DEPTH=2): directed steps plus random frames
// checked against a queue-based moving-average model.
module tb_als_light_filter;

    localparam int PERIOD   = 64;
    localparam int TICK     = 32;
    localparam int DEPTH    = 4;
    localparam int THRESH_H = 160;
    localparam int THRESH_L = 96;
`ifdef ALS_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [7:0]  light;
    logic        light_valid;
    logic        bright;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    int window[$];
    int modelLight   = 0;
    int modelBright  = 0;
    int modelErrCnt  = 0;
    int lvCount;
    int lvPhase;
    int feCount;
    int fePhase;

    als_light_filter #(
        .CNT_W     (6),
        .LOG2_DEPTH(2),
        .THRESH_HI (8'd160),
        .THRESH_LO (8'd96)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .value_in   (value_in),
        .light      (light),
        .light_valid(light_valid),
        .bright     (bright),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference behaviour: last DEPTH accepted codes, truncated mean, hysteresis on each new mean
    task automatic modelSample(input logic [15:0] frame, output bit expValid, output bit expErr);
        int sum;
        expValid = 1'b0;
        expErr   = 1'b0;
        if (FRAME_CHECK && ((frame[15:12] != 4'h0) || (frame[3:0] != 4'h0))) begin
            expErr = 1'b1;
            if (modelErrCnt < 255) modelErrCnt++;
        end else begin
            window.push_back(int'(frame[11:4]));
            if (window.size() > DEPTH) window.delete(0);
            if (window.size() == DEPTH) begin
                expValid = 1'b1;
                sum = 0;
                foreach (window[k]) sum += window[k];
                modelLight = sum / DEPTH;
                if (modelLight >= THRESH_H) modelBright = 1;
                else if (modelLight <= THRESH_L) modelBright = 0;
            end
        end
    endtask

    // Runs one full sample period starting at timer 0 and checks pulses and outputs
    task automatic applyStimulus(input logic [15:0] frame, input string tag);
        bit expValid;
        bit expErr;
        value_in = frame;
        lvCount  = 0;
        lvPhase  = -1;
        feCount  = 0;
        fePhase  = -1;
        for (int c = 1; c <= PERIOD; c++) begin
            @(posedge clock);
            #1;
            if (light_valid !== 1'b0) begin
                lvCount++;
                lvPhase = c % PERIOD;
            end
            if (frame_err !== 1'b0) begin
                feCount++;
                fePhase = c % PERIOD;
            end
        end
        modelSample(frame, expValid, expErr);
        checkOutput({tag, "_lvCount"}, lvCount, expValid ? 1 : 0);
        if (expValid) checkOutput({tag, "_lvPhase"}, lvPhase, TICK + 2);
        checkOutput({tag, "_feCount"}, feCount, expErr ? 1 : 0);
        if (expErr) checkOutput({tag, "_fePhase"}, fePhase, TICK + 1);
        checkOutput({tag, "_light"}, light, modelLight);
        checkOutput({tag, "_bright"}, bright, modelBright);
        checkOutput({tag, "_errCnt"}, err_cnt, modelErrCnt);
    endtask

    // Asserts reset during cycle T+1 of a period, before the buffer write
    task automatic resetMidWindow(input logic [15:0] frame);
        value_in = frame;
        for (int c = 1; c <= TICK + 1; c++) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_light", light, 0);
        checkOutput("rst_bright", bright, 0);
        checkOutput("rst_lightValid", light_valid, 0);
        checkOutput("rst_errCnt", err_cnt, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            checkOutput("rst_holdLightValid", light_valid, 0);
            checkOutput("rst_holdFrameErr", frame_err, 0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        window.delete();
        modelLight  = 0;
        modelBright = 0;
        modelErrCnt = 0;
    endtask

    initial begin
        logic [15:0] frame;
        logic [7:0]  code;

        value_in = 16'h0640;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_light", light, 0);
        checkOutput("reset_lightValid", light_valid, 0);
        checkOutput("reset_bright", bright, 0);
        checkOutput("reset_frameErr", frame_err, 0);
        checkOutput("reset_errCnt", err_cnt, 0);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] warm-up with code 100");
        for (int i = 0; i < 4; i++) applyStimulus(16'h0640, $sformatf("warm%0d", i));
        checkOutput("warm_light100", light, 100);

        $display("[TB] hysteresis sequence");
        for (int i = 0; i < 4; i++) applyStimulus({4'h0, 8'd200, 4'h0}, $sformatf("hi%0d", i));
        for (int i = 0; i < 4; i++) applyStimulus({4'h0, 8'd120, 4'h0}, $sformatf("mid%0d", i));
        for (int i = 0; i < 3; i++) applyStimulus({4'h0, 8'd80, 4'h0}, $sformatf("lo%0d", i));
        checkOutput("hyst_light90", light, 90);
        checkOutput("hyst_brightOff", bright, 0);

        $display("[TB] window wrap");
        for (int i = 1; i <= 5; i++) applyStimulus({4'h0, 8'(i * 4), 4'h0}, $sformatf("wrap%0d", i));
        checkOutput("wrap_light14", light, 14);

        $display("[TB] malformed frames");
        applyStimulus(16'h2640, "bad0");
        applyStimulus(16'h0640, "afterBad");
        for (int i = 0; i < 300; i++) applyStimulus(16'h2640, $sformatf("badRun%0d", i));

        $display("[TB] reset mid-window");
        resetMidWindow(16'h0640);

        $display("[TB] full scale");
        for (int i = 0; i < 4; i++) applyStimulus({4'h0, 8'd255, 4'h0}, $sformatf("full%0d", i));
        checkOutput("full_light255", light, 255);
        for (int i = 0; i < 4; i++) applyStimulus(16'h0000, $sformatf("zero%0d", i));
        checkOutput("zero_light0", light, 0);
        checkOutput("zero_bright0", bright, 0);

        $display("[TB] random frames");
        for (int i = 0; i < 24; i++) begin
            code = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) frame = 16'($urandom());
            else frame = {4'h0, code, 4'h0};
            applyStimulus(frame, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
